instruction_decode_stage: RTL and testbench

INSTRUCTION_DECODE_STAGE -- requirements
Module: instruction_decode_stage

---
 rtl/instruction_decode_stage.sv | 223 ++++++++++++++++++++++
 tb/tb_instruction_decode_stage.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_decode_stage.sv
// RV32I decode stage: register file, immediate/control decode, load-use hazard detection, ID/EX pipeline register.
// Latency: one cycle from an accepted instruction to ID/EX; register reads are combinational.
// Backpressure: in_ready drops on load-use stall or a full ID/EX held by !ex_ready; flush overrides everything.
// Optional feature: define DECODE_BYPASS_EN to forward same-cycle writeback data into the operand reads.
module instruction_decode_stage #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [2:0]      ex_funct3,
  output logic            ex_alt,
  output logic [7:0]      ex_ctrl,
  output logic            stall
);

  localparam int RAW = $clog2(NUM_REGS);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_CUST0  = 7'b0001011;

  // ex_ctrl bit positions, MSB first
  localparam int C_REG_WRITE = 7;
  localparam int C_MEM_READ  = 6;
  localparam int C_MEM_WRITE = 5;
  localparam int C_BRANCH    = 4;
  localparam int C_JUMP      = 3;
  localparam int C_ALU_IMM   = 2;
  localparam int C_PC_REL    = 1;
  localparam int C_SWITCH    = 0;

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];

  logic [XLEN-1:0] rf [NUM_REGS];
  logic            rs1_in_range;
  logic            rs2_in_range;
  logic            wb_in_range;
  assign rs1_in_range = ({27'd0, rs1} < 32'(NUM_REGS));
  assign rs2_in_range = ({27'd0, rs2} < 32'(NUM_REGS));
  assign wb_in_range  = ({27'd0, wb_addr} < 32'(NUM_REGS));

  // Register file: async clear; x0 and out-of-range indices are never written
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else if (wb_en && (wb_addr != 5'd0) && wb_in_range) begin
      rf[wb_addr[RAW-1:0]] <= wb_data;
    end
  end

  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;

  // Combinational operand read; x0 and out-of-range indices read as zero
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if ((rs1 != 5'd0) && rs1_in_range) begin
      rs1_data = rf[rs1[RAW-1:0]];
`ifdef DECODE_BYPASS_EN
      if (wb_en && (wb_addr == rs1)) rs1_data = wb_data;
`endif
    end
    if ((rs2 != 5'd0) && rs2_in_range) begin
      rs2_data = rf[rs2[RAW-1:0]];
`ifdef DECODE_BYPASS_EN
      if (wb_en && (wb_addr == rs2)) rs2_data = wb_data;
`endif
    end
  end

  logic [7:0]         dec_ctrl;
  logic signed [31:0] imm32;
  logic [XLEN-1:0]    dec_imm;
  logic               uses_rs1;
  logic               uses_rs2;

  // Opcode decode: control bundle, immediate format and which sources are really read
  always_comb begin
    dec_ctrl = '0;
    imm32    = '0;
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    case (opcode)
      OP_LUI: begin
        dec_ctrl[C_REG_WRITE] = 1'b1;
        dec_ctrl[C_ALU_IMM]   = 1'b1;
        imm32    = {in_instr[31:12], 12'b0};
        uses_rs1 = 1'b0;
      end
      OP_AUIPC: begin
        dec_ctrl[C_REG_WRITE] = 1'b1;
        dec_ctrl[C_ALU_IMM]   = 1'b1;
        dec_ctrl[C_PC_REL]    = 1'b1;
        imm32    = {in_instr[31:12], 12'b0};
        uses_rs1 = 1'b0;
      end
      OP_JAL: begin
        dec_ctrl[C_REG_WRITE] = 1'b1;
        dec_ctrl[C_JUMP]      = 1'b1;
        dec_ctrl[C_PC_REL]    = 1'b1;
        imm32    = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
        uses_rs1 = 1'b0;
      end
      OP_JALR: begin
        dec_ctrl[C_REG_WRITE] = 1'b1;
        dec_ctrl[C_JUMP]      = 1'b1;
        dec_ctrl[C_ALU_IMM]   = 1'b1;
        imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OP_BRANCH: begin
        dec_ctrl[C_BRANCH] = 1'b1;
        dec_ctrl[C_PC_REL] = 1'b1;
        imm32    = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
        uses_rs2 = 1'b1;
      end
      OP_LOAD: begin
        dec_ctrl[C_REG_WRITE] = 1'b1;
        dec_ctrl[C_MEM_READ]  = 1'b1;
        dec_ctrl[C_ALU_IMM]   = 1'b1;
        imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OP_STORE: begin
        dec_ctrl[C_MEM_WRITE] = 1'b1;
        dec_ctrl[C_ALU_IMM]   = 1'b1;
        imm32    = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        uses_rs2 = 1'b1;
      end
      OP_IMM: begin
        dec_ctrl[C_REG_WRITE] = 1'b1;
        dec_ctrl[C_ALU_IMM]   = 1'b1;
        imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OP_OP: begin
        dec_ctrl[C_REG_WRITE] = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_CUST0: begin
        dec_ctrl[C_SWITCH] = 1'b1;
        imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      default: begin
        dec_ctrl = '0;
      end
    endcase
  end

  // Size cast of a signed value sign-extends to XLEN
  assign dec_imm = XLEN'(imm32);

  assign stall = in_valid && ex_valid && ex_ctrl[C_MEM_READ] && (ex_rd != 5'd0) &&
                 ((uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd)));

  assign in_ready = !stall && (!ex_valid || ex_ready);

  // ID/EX register: flush kills, accepted instruction loads, drained slot becomes a bubble, else hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid    <= 1'b0;
      ex_ctrl     <= '0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rd       <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_funct3   <= '0;
      ex_alt      <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
    end else if (in_valid && in_ready) begin
      ex_valid    <= 1'b1;
      ex_ctrl     <= dec_ctrl;
      ex_pc       <= in_pc;
      ex_rs1_data <= rs1_data;
      ex_rs2_data <= rs2_data;
      ex_imm      <= dec_imm;
      ex_rd       <= rd;
      ex_rs1      <= rs1;
      ex_rs2      <= rs2;
      ex_funct3   <= in_instr[14:12];
      ex_alt      <= in_instr[30];
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
    end
  end

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Bench for instruction_decode_stage: scoreboard of expected ID/EX contents pushed when an
// instruction is presented and popped when it appears in ID/EX.
module tb_instruction_decode_stage;
  localparam int XLEN = 32;

  logic            clk;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            flush;
  logic            wb_en;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            ex_ready;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [XLEN-1:0] ex_imm;
  logic [4:0]      ex_rd;
  logic [4:0]      ex_rs1;
  logic [4:0]      ex_rs2;
  logic [2:0]      ex_funct3;
  logic            ex_alt;
  logic [7:0]      ex_ctrl;
  logic            stall;

  instruction_decode_stage #(.XLEN(XLEN), .NUM_REGS(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_funct3(ex_funct3),
    .ex_alt(ex_alt), .ex_ctrl(ex_ctrl), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] I_ADDI_6_5_1 = 32'h00128313; // addi x6,x5,1
  localparam logic [31:0] I_LW_7_0_1   = 32'h0000A383; // lw   x7,0(x1)
  localparam logic [31:0] I_ADD_8_7_2  = 32'h00238433; // add  x8,x7,x2
  localparam logic [31:0] I_LUI_9      = 32'h123454B7; // lui  x9,0x12345
  localparam logic [31:0] I_ADDI_4_3_0 = 32'h00018213; // addi x4,x3,0
  localparam logic [31:0] I_ADDI_4_0_0 = 32'h00000213; // addi x4,x0,0

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [2:0]      f3;
    logic            alt;
    logic [7:0]      ctrl;
    bit              chk_ops;
    bit              chk_imm;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total;
  int   passed;

  function automatic void sb_push(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] rs1,
                                  input logic [XLEN-1:0] rs2, input logic [XLEN-1:0] imm,
                                  input logic [4:0] rd, input logic [2:0] f3, input logic alt,
                                  input logic [7:0] ctrl, input bit chk_ops, input bit chk_imm);
    exp_t x;
    x.pc = pc; x.rs1 = rs1; x.rs2 = rs2; x.imm = imm; x.rd = rd; x.f3 = f3;
    x.alt = alt; x.ctrl = ctrl; x.chk_ops = chk_ops; x.chk_imm = chk_imm;
    sb.push_back(x);
  endfunction

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_instr = I_ADDI_6_5_1; in_pc = 32'h10;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({ex_valid, ex_ctrl, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rd, ex_rs1, ex_rs2, ex_funct3, ex_alt} !== '0)
      $display("FAIL reset_state: v=%b ctrl=%h pc=%h imm=%h rd=%0d", ex_valid, ex_ctrl, ex_pc, ex_imm, ex_rd);
    else passed++;
    total++;
    if ({in_ready, stall} !== 2'b10)
      $display("FAIL reset_handshake: in_ready=%b stall=%b, want in_ready=1 stall=0", in_ready, stall);
    else passed++;
    reset = 1'b0;
    sb_push(32'h10, 0, 0, 1, 5'd6, 3'd0, 1'b0, 8'h84, 1, 1);
    @(posedge clk); #1;
    total++;
    if (sb.size() == 0) $display("FAIL reset_first_sb: no expected entry");
    else begin
      e = sb.pop_front();
      if ({ex_valid, ex_pc, ex_rd, ex_funct3, ex_alt, ex_ctrl, ex_imm} !== {1'b1, e.pc, e.rd, e.f3, e.alt, e.ctrl, e.imm})
        $display("FAIL reset_first_capture: v=%b pc=%h rd=%0d ctrl=%h imm=%h, want v=1 pc=%h rd=%0d ctrl=%h imm=%h",
                 ex_valid, ex_pc, ex_rd, ex_ctrl, ex_imm, e.pc, e.rd, e.ctrl, e.imm);
      else passed++;
    end
    @(negedge clk); in_valid = 1'b0;
  endtask

  task automatic test_writeback_addi();
    @(negedge clk); wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hAA;
    @(negedge clk); wb_en = 1'b0; in_valid = 1'b1; in_instr = I_ADDI_6_5_1; in_pc = 32'h100;
    sb_push(32'h100, 32'hAA, 0, 1, 5'd6, 3'd0, 1'b0, 8'h84, 1, 1);
    @(posedge clk); #1;
    total++;
    if (sb.size() == 0) $display("FAIL addi_sb: no expected entry");
    else begin
      e = sb.pop_front();
      if ({ex_valid, ex_pc, ex_rd, ex_funct3, ex_alt, ex_ctrl, ex_imm, ex_rs1_data, ex_rs2_data} !==
          {1'b1, e.pc, e.rd, e.f3, e.alt, e.ctrl, e.imm, e.rs1, e.rs2})
        $display("FAIL addi_capture: v=%b pc=%h ctrl=%h imm=%h rs1=%h rs2=%h, want v=1 pc=%h ctrl=%h imm=%h rs1=%h rs2=%h",
                 ex_valid, ex_pc, ex_ctrl, ex_imm, ex_rs1_data, ex_rs2_data, e.pc, e.ctrl, e.imm, e.rs1, e.rs2);
      else passed++;
    end
    @(negedge clk); in_valid = 1'b0;
  endtask

  task automatic test_load_use();
    @(negedge clk); wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'h22;
    @(negedge clk); wb_en = 1'b0; in_valid = 1'b1; in_instr = I_LW_7_0_1; in_pc = 32'h200;
    sb_push(32'h200, 0, 0, 0, 5'd7, 3'd2, 1'b0, 8'hC4, 1, 1);
    @(posedge clk); #1;
    total++;
    if (sb.size() == 0) $display("FAIL lw_sb: no expected entry");
    else begin
      e = sb.pop_front();
      if ({ex_valid, ex_pc, ex_rd, ex_funct3, ex_ctrl, ex_imm} !== {1'b1, e.pc, e.rd, e.f3, e.ctrl, e.imm})
        $display("FAIL lw_capture: v=%b pc=%h rd=%0d ctrl=%h, want v=1 pc=%h rd=%0d ctrl=%h",
                 ex_valid, ex_pc, ex_rd, ex_ctrl, e.pc, e.rd, e.ctrl);
      else passed++;
    end
    @(negedge clk); in_instr = I_ADD_8_7_2; in_pc = 32'h204; #1;
    total++;
    if ({stall, in_ready} !== 2'b10)
      $display("FAIL load_use_stall: stall=%b in_ready=%b, want stall=1 in_ready=0", stall, in_ready);
    else passed++;
    @(posedge clk); #1;
    total++;
    if ({ex_valid, ex_ctrl} !== 9'd0)
      $display("FAIL load_use_bubble: v=%b ctrl=%h, want v=0 ctrl=00", ex_valid, ex_ctrl);
    else passed++;
    @(negedge clk); #1;
    total++;
    if ({stall, in_ready} !== 2'b01)
      $display("FAIL load_use_release: stall=%b in_ready=%b, want stall=0 in_ready=1", stall, in_ready);
    else passed++;
    sb_push(32'h204, 0, 32'h22, 0, 5'd8, 3'd0, 1'b0, 8'h80, 1, 0);
    @(posedge clk); #1;
    total++;
    if (sb.size() == 0) $display("FAIL add_sb: no expected entry");
    else begin
      e = sb.pop_front();
      if ({ex_valid, ex_pc, ex_rd, ex_ctrl, ex_rs1_data, ex_rs2_data} !== {1'b1, e.pc, e.rd, e.ctrl, e.rs1, e.rs2})
        $display("FAIL add_capture: v=%b pc=%h rd=%0d ctrl=%h rs1=%h rs2=%h, want v=1 pc=%h rd=%0d ctrl=%h rs1=%h rs2=%h",
                 ex_valid, ex_pc, ex_rd, ex_ctrl, ex_rs1_data, ex_rs2_data, e.pc, e.rd, e.ctrl, e.rs1, e.rs2);
      else passed++;
    end
    @(negedge clk); in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    @(negedge clk); in_valid = 1'b1; in_instr = I_ADDI_6_5_1; in_pc = 32'h300;
    sb_push(32'h300, 32'hAA, 0, 1, 5'd6, 3'd0, 1'b0, 8'h84, 1, 1);
    @(posedge clk); #1;
    total++;
    if (sb.size() == 0) $display("FAIL bp_load_sb: no expected entry");
    else begin
      e = sb.pop_front();
      if ({ex_valid, ex_pc, ex_ctrl, ex_imm, ex_rs1_data} !== {1'b1, e.pc, e.ctrl, e.imm, e.rs1})
        $display("FAIL bp_load: v=%b pc=%h ctrl=%h imm=%h rs1=%h", ex_valid, ex_pc, ex_ctrl, ex_imm, ex_rs1_data);
      else passed++;
    end
    @(negedge clk); ex_ready = 1'b0; in_instr = I_LUI_9; in_pc = 32'h304; #1;
    total++;
    if (in_ready !== 1'b0) $display("FAIL bp_in_ready: in_ready=%b, want 0", in_ready);
    else passed++;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      total++;
      if ({ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rd, ex_rs1, ex_rs2, ex_ctrl, in_ready} !==
          {1'b1, 32'h300, 32'hAA, 32'h0, 32'h1, 5'd6, 5'd5, 5'd1, 8'h84, 1'b0})
        $display("FAIL bp_hold_%0d: v=%b pc=%h rs1=%h imm=%h rd=%0d ctrl=%h in_ready=%b, want v=1 pc=300 rs1=aa imm=1 rd=6 ctrl=84 in_ready=0",
                 k, ex_valid, ex_pc, ex_rs1_data, ex_imm, ex_rd, ex_ctrl, in_ready);
      else passed++;
    end
    @(negedge clk); ex_ready = 1'b1; #1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL bp_resume_ready: in_ready=%b, want 1", in_ready);
    else passed++;
    sb_push(32'h304, 0, 0, 32'h12345000, 5'd9, 3'd5, 1'b0, 8'h84, 0, 1);
    @(posedge clk); #1;
    total++;
    if (sb.size() == 0) $display("FAIL lui_sb: no expected entry");
    else begin
      e = sb.pop_front();
      if ({ex_valid, ex_pc, ex_rd, ex_funct3, ex_ctrl, ex_imm} !== {1'b1, e.pc, e.rd, e.f3, e.ctrl, e.imm})
        $display("FAIL lui_capture: v=%b pc=%h rd=%0d f3=%0d ctrl=%h imm=%h, want v=1 pc=%h rd=%0d f3=%0d ctrl=%h imm=%h",
                 ex_valid, ex_pc, ex_rd, ex_funct3, ex_ctrl, ex_imm, e.pc, e.rd, e.f3, e.ctrl, e.imm);
      else passed++;
    end
    @(negedge clk); in_valid = 1'b0;
  endtask

  task automatic test_flush();
    @(negedge clk); in_valid = 1'b1; in_instr = I_ADDI_6_5_1; in_pc = 32'h400;
    sb_push(32'h400, 32'hAA, 0, 1, 5'd6, 3'd0, 1'b0, 8'h84, 1, 1);
    @(posedge clk); #1;
    total++;
    if (sb.size() == 0) $display("FAIL flush_pre_sb: no expected entry");
    else begin
      e = sb.pop_front();
      if ({ex_valid, ex_pc, ex_ctrl} !== {1'b1, e.pc, e.ctrl})
        $display("FAIL flush_pre: v=%b pc=%h ctrl=%h, want v=1 pc=%h ctrl=%h", ex_valid, ex_pc, ex_ctrl, e.pc, e.ctrl);
      else passed++;
    end
    @(negedge clk); flush = 1'b1; ex_ready = 1'b0; in_instr = I_LW_7_0_1; in_pc = 32'h404;
    @(posedge clk); #1;
    total++;
    if ({ex_valid, ex_ctrl} !== 9'd0)
      $display("FAIL flush_kill: v=%b ctrl=%h, want v=0 ctrl=00", ex_valid, ex_ctrl);
    else passed++;
    @(negedge clk); flush = 1'b0; ex_ready = 1'b1; in_instr = I_ADDI_6_5_1; in_pc = 32'h408;
    sb_push(32'h408, 32'hAA, 0, 1, 5'd6, 3'd0, 1'b0, 8'h84, 1, 1);
    @(posedge clk); #1;
    total++;
    if (sb.size() == 0) $display("FAIL flush_post_sb: no expected entry");
    else begin
      e = sb.pop_front();
      if ({ex_valid, ex_pc, ex_ctrl, ex_rs1_data} !== {1'b1, e.pc, e.ctrl, e.rs1})
        $display("FAIL flush_rf_intact: v=%b pc=%h ctrl=%h rs1=%h, want v=1 pc=%h ctrl=%h rs1=%h",
                 ex_valid, ex_pc, ex_ctrl, ex_rs1_data, e.pc, e.ctrl, e.rs1);
      else passed++;
    end
    @(negedge clk); in_valid = 1'b0;
  endtask

  task automatic test_wb_same_cycle();
    logic [XLEN-1:0] same_cycle_x3;
`ifdef DECODE_BYPASS_EN
    same_cycle_x3 = 32'h1234;
`else
    same_cycle_x3 = 32'h0;
`endif
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_pc    = 32'h500 + 32'(k * 4);
      wb_en    = (k == 0) || (k == 2);
      wb_addr  = (k < 2) ? 5'd3 : 5'd0;
      wb_data  = (k < 2) ? 32'h1234 : 32'hDEAD;
      in_instr = (k < 2) ? I_ADDI_4_3_0 : I_ADDI_4_0_0;
      sb_push(in_pc, (k == 0) ? same_cycle_x3 : ((k == 1) ? 32'h1234 : 32'h0), 0, 0,
              5'd4, 3'd0, 1'b0, 8'h84, 1, 1);
      @(posedge clk); #1;
      total++;
      if (sb.size() == 0) $display("FAIL wb_rd_%0d_sb: no expected entry", k);
      else begin
        e = sb.pop_front();
        if ({ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm} !== {1'b1, e.pc, e.rs1, e.rs2, e.imm})
          $display("FAIL wb_rd_%0d: v=%b pc=%h rs1=%h rs2=%h, want v=1 pc=%h rs1=%h rs2=%h",
                   k, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, e.pc, e.rs1, e.rs2);
        else passed++;
      end
    end
    @(negedge clk); in_valid = 1'b0; wb_en = 1'b0;
  endtask

  task automatic test_back_to_back_formats();
    logic [31:0]     t_instr [4];
    logic [7:0]      t_ctrl  [4];
    logic [XLEN-1:0] t_imm   [4];
    logic [4:0]      t_rd    [4];
    logic [2:0]      t_f3    [4];
    logic            t_alt   [4];
    bit              t_chk   [4];
    t_instr[0] = 32'h0000000B; t_ctrl[0] = 8'h01; t_imm[0] = 0; t_rd[0] = 5'd0;  t_f3[0] = 3'd0; t_alt[0] = 1'b0; t_chk[0] = 0;
    t_instr[1] = 32'hFE208EE3; t_ctrl[1] = 8'h12; t_imm[1] = {{(XLEN-3){1'b1}}, 3'b100};
    t_rd[1] = 5'd29; t_f3[1] = 3'd0; t_alt[1] = 1'b1; t_chk[1] = 1;
    t_instr[2] = 32'hFE20AC23; t_ctrl[2] = 8'h24; t_imm[2] = {{(XLEN-4){1'b1}}, 4'b1000};
    t_rd[2] = 5'd24; t_f3[2] = 3'd2; t_alt[2] = 1'b1; t_chk[2] = 1;
    t_instr[3] = 32'h0000007F; t_ctrl[3] = 8'h00; t_imm[3] = 0; t_rd[3] = 5'd0;  t_f3[3] = 3'd0; t_alt[3] = 1'b0; t_chk[3] = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_instr = t_instr[k]; in_pc = 32'h600 + 32'(k * 4);
      sb_push(in_pc, 0, 32'h22, t_imm[k], t_rd[k], t_f3[k], t_alt[k], t_ctrl[k], t_chk[k], t_chk[k]);
      @(posedge clk); #1;
      total++;
      if (sb.size() == 0) $display("FAIL fmt_%0d_sb: no expected entry", k);
      else begin
        e = sb.pop_front();
        if ({ex_pc, ex_rd, ex_funct3, ex_alt, ex_ctrl} !== {e.pc, e.rd, e.f3, e.alt, e.ctrl})
          $display("FAIL fmt_%0d_ctrl: pc=%h rd=%0d f3=%0d alt=%b ctrl=%h, want pc=%h rd=%0d f3=%0d alt=%b ctrl=%h",
                   k, ex_pc, ex_rd, ex_funct3, ex_alt, ex_ctrl, e.pc, e.rd, e.f3, e.alt, e.ctrl);
        else passed++;
        if (e.chk_imm) begin
          total++;
          if ({ex_imm, ex_rs1_data, ex_rs2_data} !== {e.imm, e.rs1, e.rs2})
            $display("FAIL fmt_%0d_imm_ops: imm=%h rs1=%h rs2=%h, want imm=%h rs1=%h rs2=%h",
                     k, ex_imm, ex_rs1_data, ex_rs2_data, e.imm, e.rs1, e.rs2);
          else passed++;
        end
      end
    end
    @(negedge clk); in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    @(negedge clk); in_valid = 1'b1; in_instr = I_LW_7_0_1; in_pc = 32'h700;
    sb_push(32'h700, 0, 0, 0, 5'd7, 3'd2, 1'b0, 8'hC4, 1, 1);
    @(posedge clk); #1;
    total++;
    if (sb.size() == 0) $display("FAIL rst_lw_sb: no expected entry");
    else begin
      e = sb.pop_front();
      if ({ex_valid, ex_pc, ex_ctrl} !== {1'b1, e.pc, e.ctrl})
        $display("FAIL rst_lw_capture: v=%b pc=%h ctrl=%h, want v=1 pc=%h ctrl=%h", ex_valid, ex_pc, ex_ctrl, e.pc, e.ctrl);
      else passed++;
    end
    @(negedge clk); in_instr = I_ADD_8_7_2; in_pc = 32'h704; #1;
    total++;
    if (stall !== 1'b1) $display("FAIL rst_pre_stall: stall=%b, want 1", stall);
    else passed++;
    #1 reset = 1'b1; #1;
    total++;
    if ({ex_valid, ex_ctrl, ex_pc, ex_imm, ex_rd, stall, in_ready} !== {1'b0, 8'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1})
      $display("FAIL rst_async: v=%b ctrl=%h pc=%h imm=%h rd=%0d stall=%b in_ready=%b, want all zero with in_ready=1",
               ex_valid, ex_ctrl, ex_pc, ex_imm, ex_rd, stall, in_ready);
    else passed++;
    @(posedge clk);
    @(negedge clk); reset = 1'b0;
    sb_push(32'h704, 0, 0, 0, 5'd8, 3'd0, 1'b0, 8'h80, 1, 0);
    @(posedge clk); #1;
    total++;
    if (sb.size() == 0) $display("FAIL rst_replay_sb: no expected entry");
    else begin
      e = sb.pop_front();
      if ({ex_valid, ex_pc, ex_rd, ex_ctrl, ex_rs1_data, ex_rs2_data} !== {1'b1, e.pc, e.rd, e.ctrl, e.rs1, e.rs2})
        $display("FAIL rst_replay: v=%b pc=%h rd=%0d ctrl=%h rs2=%h, want v=1 pc=%h rd=%0d ctrl=%h rs2=%h",
                 ex_valid, ex_pc, ex_rd, ex_ctrl, ex_rs2_data, e.pc, e.rd, e.ctrl, e.rs2);
      else passed++;
    end
    @(negedge clk); in_valid = 1'b0;
  endtask

  initial begin
    total = 0; passed = 0;
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; ex_ready = 1'b1;
    test_reset();
    test_writeback_addi();
    test_load_use();
    test_backpressure();
    test_flush();
    test_wb_same_cycle();
    test_back_to_back_formats();
    test_reset_mid_stall();
    total++;
    if (sb.size() != 0) $display("FAIL sb_drain: %0d entries left, want 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
